// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency memory between the
// instruction fetch path and the data (load/store) path of the MIPS core.
// Data requests win arbitration, but a streak counter bounds how many data
// grants in a row may pass a waiting fetch. Each granted transaction is
// latched, issued on the memory handshake, and completed with a one-cycle
// ready pulse; a hung transaction is aborted after TIMEOUT issue cycles.
module mem_arbiter #(
   parameter int WIDTH       = 32,
   parameter int MAX_DSTREAK = 4,
   parameter int TIMEOUT     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ireq,
   input  logic [WIDTH-1:0] iaddr,
   output logic [WIDTH-1:0] irdata,
   output logic             iready,
   input  logic             dreq,
   input  logic             dwe,
   input  logic [WIDTH-1:0] daddr,
   input  logic [WIDTH-1:0] dwdata,
   output logic [WIDTH-1:0] drdata,
   output logic             dready,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack,
   output logic             err,
   output logic             stallF,
   output logic             stallM
);

   // Transaction phases: wait for a request, hold the memory request until
   // ack/timeout, then spend one cycle presenting the ready pulse.
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
   localparam logic [7:0] TO_LIMIT   = 8'(TIMEOUT);
   localparam bit         TO_EN      = (TIMEOUT != 0);

   // Saturating increments keep the counters from wrapping when the
   // timeout is disabled or a streak would overflow its field.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   logic [1:0]       state_q, state_d;
   logic             gnt_dat_q, gnt_dat_d;   // 1 = data side owns the transaction
   logic             abort_q, abort_d;
   logic [3:0]       streak_q, streak_d;
   logic [7:0]       tcnt_q, tcnt_d;
   logic             mem_we_q, mem_we_d;
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [WIDTH-1:0] irdata_q, irdata_d;
   logic [WIDTH-1:0] drdata_q, drdata_d;

   logic             grant_dat;

   // A data request is granted unless a fetch is waiting and the data side
   // has already used up its allowed run of consecutive grants.
   assign grant_dat = dreq && (!ireq || (streak_q < STREAK_MAX));

   // Next-state logic for arbitration, issue/timeout and response capture.
   always_comb begin
      state_d     = state_q;
      gnt_dat_d   = gnt_dat_q;
      abort_d     = abort_q;
      streak_d    = streak_q;
      tcnt_d      = tcnt_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      irdata_d    = irdata_q;
      drdata_d    = drdata_q;

      case (state_q)
         S_IDLE: begin
            if (grant_dat) begin
               gnt_dat_d   = 1'b1;
               mem_we_d    = dwe;
               mem_addr_d  = daddr;
               mem_wdata_d = dwdata;
               tcnt_d      = 8'd0;
               abort_d     = 1'b0;
               // Only a grant that actually passes a waiting fetch counts.
               streak_d    = ireq ? sat_inc4(streak_q) : 4'd0;
               state_d     = S_ISSUE;
            end else if (ireq) begin
               gnt_dat_d  = 1'b0;
               mem_we_d   = 1'b0;
               mem_addr_d = iaddr;
               tcnt_d     = 8'd0;
               abort_d    = 1'b0;
               streak_d   = 4'd0;
               state_d    = S_ISSUE;
            end
         end

         S_ISSUE: begin
            if (mem_ack) begin
               // Stores return nothing, so drdata keeps its last load value.
               if (!gnt_dat_q) begin
                  irdata_d = mem_rdata;
               end else if (!mem_we_q) begin
                  drdata_d = mem_rdata;
               end
               state_d = S_RESP;
            end else begin
               tcnt_d = sat_inc8(tcnt_q);
               if (TO_EN && (tcnt_d == TO_LIMIT)) begin
                  abort_d = 1'b1;
                  if (gnt_dat_q) begin
                     drdata_d = '0;
                  end else begin
                     irdata_d = '0;
                  end
                  state_d = S_RESP;
               end
            end
         end

         S_RESP: begin
            // Requesters update their requests after ready; do not resample here.
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset drops any transaction in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         gnt_dat_q   <= 1'b0;
         abort_q     <= 1'b0;
         streak_q    <= 4'd0;
         tcnt_q      <= 8'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         irdata_q    <= '0;
         drdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         gnt_dat_q   <= gnt_dat_d;
         abort_q     <= abort_d;
         streak_q    <= streak_d;
         tcnt_q      <= tcnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         irdata_q    <= irdata_d;
         drdata_q    <= drdata_d;
      end
   end

   // Handshake and ready/err pulses decode directly from the state, so an
   // asynchronous reset silences them in the same instant.
   assign mem_req   = (state_q == S_ISSUE);
   assign mem_we    = mem_req & mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign irdata    = irdata_q;
   assign drdata    = drdata_q;
   assign iready    = (state_q == S_RESP) & ~gnt_dat_q;
   assign dready    = (state_q == S_RESP) & gnt_dat_q;
   assign err       = (state_q == S_RESP) & abort_q;
   assign stallF    = ireq & ~iready;
   assign stallM    = dreq & ~dready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, store, starvation bound,
// timeout abort and mid-transaction reset, with hand-computed expectations.
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        ireq, dreq, dwe, mem_ack;
   logic [31:0] iaddr, daddr, dwdata, mem_rdata;
   logic [31:0] irdata, drdata, mem_addr, mem_wdata;
   logic        iready, dready, mem_req, mem_we, err, stallF, stallM;

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.WIDTH(32), .MAX_DSTREAK(4), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iready(iready),
      .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
      .drdata(drdata), .dready(dready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .err(err), .stallF(stallF), .stallM(stallM)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Advance to just after the next rising edge (input drive point).
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bit seen;
      reset = 1'b1; ireq = 0; dreq = 0; dwe = 0; mem_ack = 0;
      iaddr = 0; daddr = 0; dwdata = 0; mem_rdata = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_ready", {30'd0, iready, dready}, 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_irdata", irdata, 0);
      chk("rst_drdata", drdata, 0);

      // Fetch only, immediate ack.
      cyc(); ireq = 1; iaddr = 32'h40;
      @(negedge clk);
      chk("f_c0_req", 32'(mem_req), 0);
      chk("f_c0_stallF", 32'(stallF), 1);
      cyc(); mem_ack = 1; mem_rdata = 32'h20020005;
      @(negedge clk);
      chk("f_c1_req", 32'(mem_req), 1);
      chk("f_c1_addr", mem_addr, 32'h40);
      chk("f_c1_we", 32'(mem_we), 0);
      cyc(); mem_ack = 0;
      @(negedge clk);
      chk("f_c2_iready", 32'(iready), 1);
      chk("f_c2_irdata", irdata, 32'h20020005);
      chk("f_c2_stallF", 32'(stallF), 0);
      chk("f_c2_err", 32'(err), 0);
      cyc(); ireq = 0;
      @(negedge clk);
      chk("f_c3_iready", 32'(iready), 0);

      // Simultaneous load and fetch: data first, then fetch.
      cyc(); dreq = 1; dwe = 0; daddr = 32'h54; ireq = 1; iaddr = 32'h44;
      @(negedge clk);
      chk("s_c0_stallM", 32'(stallM), 1);
      cyc(); mem_ack = 1; mem_rdata = 32'hAAAA0001;
      @(negedge clk);
      chk("s_c1_addr", mem_addr, 32'h54);
      cyc(); mem_ack = 0;
      @(negedge clk);
      chk("s_c2_dready", 32'(dready), 1);
      chk("s_c2_drdata", drdata, 32'hAAAA0001);
      chk("s_c2_iready", 32'(iready), 0);
      cyc(); dreq = 0;
      @(negedge clk);
      chk("s_c3_req", 32'(mem_req), 0);
      chk("s_c3_stallF", 32'(stallF), 1);
      cyc(); mem_ack = 1; mem_rdata = 32'hBBBB0002;
      @(negedge clk);
      chk("s_c4_req", 32'(mem_req), 1);
      chk("s_c4_addr", mem_addr, 32'h44);
      cyc(); mem_ack = 0;
      @(negedge clk);
      chk("s_c5_iready", 32'(iready), 1);
      chk("s_c5_irdata", irdata, 32'hBBBB0002);
      chk("s_c5_dready", 32'(dready), 0);
      cyc(); ireq = 0;

      // Store: write enable and data on the bus, drdata untouched.
      cyc(); dreq = 1; dwe = 1; daddr = 32'h54; dwdata = 32'h7;
      cyc(); mem_ack = 1; mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("st_we", 32'(mem_we), 1);
      chk("st_wdata", mem_wdata, 32'h7);
      chk("st_addr", mem_addr, 32'h54);
      cyc(); mem_ack = 0;
      @(negedge clk);
      chk("st_dready", 32'(dready), 1);
      chk("st_drdata", drdata, 32'hAAAA0001);
      chk("st_we_resp", 32'(mem_we), 0);
      cyc(); dreq = 0; dwe = 0;

      // Starvation bound: D,D,D,D then I, then streak cleared.
      cyc(); ireq = 1; iaddr = 32'h80; dreq = 1; daddr = 32'h100;
      for (int i = 0; i < 5; i++) begin
         cyc(); mem_ack = 1; mem_rdata = 32'(i);
         @(negedge clk);
         chk("sv_addr", mem_addr, (i < 4) ? 32'h100 + 32'(4 * i) : 32'h80);
         cyc(); mem_ack = 0;
         @(negedge clk);
         chk("sv_dready", 32'(dready), 32'(i < 4));
         chk("sv_iready", 32'(iready), 32'(i == 4));
         cyc(); daddr = 32'h100 + 32'(4 * (i + 1));
         if (i == 4) iaddr = 32'h84;
      end
      cyc(); mem_ack = 1;
      @(negedge clk);
      chk("sv_post_addr", mem_addr, 32'h114);
      cyc(); mem_ack = 0;
      @(negedge clk);
      chk("sv_post_dready", 32'(dready), 1);
      cyc(); dreq = 0;
      cyc(); mem_ack = 1;
      @(negedge clk);
      chk("sv_post_iaddr", mem_addr, 32'h84);
      cyc(); mem_ack = 0;
      @(negedge clk);
      chk("sv_post_iready", 32'(iready), 1);
      cyc(); ireq = 0;

      // Ack while idle is ignored.
      cyc(); mem_ack = 1;
      cyc(); mem_ack = 0;
      @(negedge clk);
      chk("idle_ack_ready", {30'd0, iready, dready}, 0);
      chk("idle_ack_req", 32'(mem_req), 0);

      // Timeout: fetch never acknowledged.
      cyc(); ireq = 1; iaddr = 32'hC0;
      cnt = 0; seen = 0;
      for (int n = 0; n < 40 && !seen; n++) begin
         cyc();
         @(negedge clk);
         if (mem_req) cnt++;
         else if (iready) begin
            seen = 1;
            chk("to_err", 32'(err), 1);
            chk("to_irdata", irdata, 0);
         end
      end
      chk("to_seen", 32'(seen), 1);
      chk("to_req_cycles", 32'(cnt), 16);
      cyc(); ireq = 0;
      @(negedge clk);
      chk("to_err_after", 32'(err), 0);
      chk("to_iready_after", 32'(iready), 0);

      // Reset in the middle of ISSUE.
      cyc(); dreq = 1; dwe = 0; daddr = 32'h60;
      cyc();
      @(negedge clk);
      chk("rm_req_before", 32'(mem_req), 1);
      #1 reset = 1'b1;
      #1;
      chk("rm_req", 32'(mem_req), 0);
      chk("rm_ready_err", {29'd0, iready, dready, err}, 0);
      chk("rm_addr", mem_addr, 0);
      dreq = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rm_after_ready", {29'd0, iready, dready, err}, 0);
      chk("rm_after_req", 32'(mem_req), 0);
      cyc(); ireq = 1; iaddr = 32'h44;
      cyc(); mem_ack = 1; mem_rdata = 32'h12345678;
      @(negedge clk);
      chk("rm_new_addr", mem_addr, 32'h44);
      cyc(); mem_ack = 0;
      @(negedge clk);
      chk("rm_new_iready", 32'(iready), 1);
      chk("rm_new_irdata", irdata, 32'h12345678);
      cyc(); ireq = 0;
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
